// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, default latencies and counter sizing for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  function automatic int cnt_w(input int m, input int d);
    return $clog2(m > d ? m : d) + 1;
  endfunction
  localparam int CNT_W = cnt_w(MULT_LAT_DEF, DIV_LAT_DEF);
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: one-shot 64-bit multiply/divide result with divide-by-zero hold of current HI/LO
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  logic [63:0] sprod, uprod;
  logic [31:0] ma, mb, uq, ur, q, r;
  logic sd, dz;
  always_comb begin
    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    sd = op == MD_DIV;
    dz = b == 32'd0;
    ma = (sd && a[31]) ? -a : a;
    mb = (sd && b[31]) ? -b : b;
    uq = dz ? 32'd0 : ma / mb;
    ur = dz ? 32'd0 : ma % mb;
    q = (sd && (a[31] ^ b[31])) ? -uq : uq;
    r = (sd && a[31]) ? -ur : ur;
    res_hi = op == MD_MULT ? sprod[63:32] : op == MD_MULTU ? uprod[63:32] : dz ? cur_hi : r;
    res_lo = op == MD_MULT ? sprod[31:0] : op == MD_MULTU ? uprod[31:0] : dz ? cur_lo : q;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide latency model, HI/LO ownership and D-stage stall generation
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        d_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);
  localparam int CW = cnt_w(MULT_LAT, DIV_LAT);
  md_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] hold_hi, hold_lo, hold_hi_n, hold_lo_n, hi_n, lo_n, res_hi, res_lo;
  mdu_calc u_calc (
    .op(op),
    .a(a),
    .b(b),
    .cur_hi(hi),
    .cur_lo(lo),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      hold_hi <= '0;
      hold_lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hi <= hi_n;
      lo <= lo_n;
      hold_hi <= hold_hi_n;
      hold_lo <= hold_lo_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hi_n = hi;
    lo_n = lo;
    hold_hi_n = hold_hi;
    hold_lo_n = hold_lo;
    if (state == IDLE) begin
      if (start) begin
        hold_hi_n = res_hi;
        hold_lo_n = res_lo;
        cnt_n = op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
        state_n = RUN;
      end else begin
        hi_n = mthi ? a : hi;
        lo_n = mtlo ? a : lo;
      end
    end else begin
      cnt_n = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi_n = hold_hi;
        lo_n = hold_lo;
        state_n = IDLE;
      end
    end
  end
  assign busy = cnt != '0;
  assign stall_md = d_md & (start | busy);
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed checks of latency, arithmetic, HI/LO writes, stall and reset abandonment
module tb_mdu_ctrl;
  import mdu_pkg::*;
  logic clk, reset, start, mthi, mtlo, d_md, busy, stall_md;
  logic [1:0] op;
  logic [31:0] a, b, hi, lo;
  int total = 0;
  int bad = 0;
  mdu_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .mthi(mthi),
    .mtlo(mtlo),
    .d_md(d_md),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .stall_md(stall_md)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!reset && busy && (start || mthi || mtlo)) begin
      bad++;
      $error("FAIL protocol: start/mthi/mtlo while busy");
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic dm);
    op = o;
    a = x;
    b = y;
    d_md = dm;
    start = 1'b1;
    #1;
    chk({tag, " stall_T"}, 32'(stall_md), 32'(dm));
    step;
    start = 1'b0;
    a = '0;
    b = '0;
    for (int i = 1; i <= lat; i++) begin
      chk($sformatf("%s busy_T+%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s stall_T+%0d", tag, i), 32'(stall_md), 32'(dm));
      step;
    end
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " stall_end"}, 32'(stall_md), 32'd0);
    d_md = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    d_md = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    step;
    step;
    reset = 1'b0;
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst stall", 32'(stall_md), 32'd0);
    // the stall release cycle must already see the committed hi, as an mfhi would
    do_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1'b1);
    chk("multu hi", hi, 32'h00000001);
    chk("multu lo", lo, 32'hFFFFFFFE);
    do_op("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 5, 1'b0);
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFFE);
    do_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b1);
    chk("div hi", hi, 32'hFFFFFFFF);
    chk("div lo", lo, 32'hFFFFFFFD);
    do_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 1'b0);
    chk("divu hi", hi, 32'd1);
    chk("divu lo", lo, 32'd3);
    mthi = 1'b1;
    a = 32'h12;
    step;
    mthi = 1'b0;
    chk("mthi12", hi, 32'h12);
    mtlo = 1'b1;
    a = 32'h34;
    step;
    mtlo = 1'b0;
    chk("mtlo34", lo, 32'h34);
    do_op("divu0", MD_DIVU, 32'd99, 32'd0, 10, 1'b1);
    chk("divu0 hi", hi, 32'h12);
    chk("divu0 lo", lo, 32'h34);
    do_op("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0);
    chk("divovf hi", hi, 32'h0);
    chk("divovf lo", lo, 32'h80000000);
    mthi = 1'b1;
    a = 32'hDEADBEEF;
    step;
    mthi = 1'b0;
    chk("mthi dead", hi, 32'hDEADBEEF);
    mtlo = 1'b1;
    a = 32'h1;
    step;
    mtlo = 1'b0;
    chk("mtlo 1", lo, 32'h1);
    chk("mthi kept", hi, 32'hDEADBEEF);
    start = 1'b1;
    mthi = 1'b1;
    op = MD_MULT;
    a = 32'd3;
    b = 32'd4;
    step;
    start = 1'b0;
    mthi = 1'b0;
    a = '0;
    b = '0;
    chk("prio busy", 32'(busy), 32'd1);
    chk("prio hi T+1", hi, 32'hDEADBEEF);
    repeat (4) step;
    chk("prio hi T+5", hi, 32'hDEADBEEF);
    step;
    chk("prio hi", hi, 32'h0);
    chk("prio lo", lo, 32'hC);
    start = 1'b1;
    op = MD_DIV;
    a = 32'd100;
    b = 32'd7;
    step;
    start = 1'b0;
    a = '0;
    b = '0;
    step;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    repeat (12) step;
    chk("abort late hi", hi, 32'h0);
    chk("abort late lo", lo, 32'h0);
    do_op("mult2", MD_MULT, 32'd6, 32'd7, 5, 1'b1);
    chk("mult2 hi", hi, 32'h0);
    chk("mult2 lo", lo, 32'd42);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
